// File: rtl/req_capture_encoder.sv
// Request capture and 4-to-2 encode front-end: sticky pending bits served as registered codes over valid/ready.
// Optional macro RR_PRIORITY_EN selects round-robin arbitration instead of fixed 3>2>1>0 priority.
module req_capture_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y3,
  input  logic             y2,
  input  logic             y1,
  input  logic             y0,
  output logic             w1,
  output logic             w0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             more,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] served_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_pending;
  logic [1:0]       r_code;
  logic             r_valid;
  logic             r_more;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_req;
  logic [3:0]       w_cand;
  logic [1:0]       w_sel;
  logic [3:0]       w_sel_oh;
  logic             w_load;
  logic [3:0]       w_pending_next;
  logic [1:0]       w_code_next;
  logic             w_valid_next;
  logic             w_more_next;
  logic             w_cnt_inc;

  function automatic logic [1:0] pick_fixed(input logic [3:0] c);
    logic [1:0] idx;
    casez (c)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

`ifdef RR_PRIORITY_EN
  logic [1:0] r_last;

  // Walk downward so the final hit is the first set bit after the last-served index.
  function automatic logic [1:0] pick_rr(input logic [3:0] c, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    res = last + 2'd1;
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'd1 + 2'(i);
      if (c[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_sel = pick_rr(w_cand, r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 2'd3;
    end else if (w_load) begin
      r_last <= w_sel;
    end
  end
`else
  assign w_sel = pick_fixed(w_cand);
`endif

  assign w_req    = {y3, y2, y1, y0};
  assign w_cand   = r_pending | w_req;
  assign w_sel_oh = 4'b0001 << w_sel;
  assign w_load   = (w_cand != 4'b0000) &&
                    ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));

  // A same-edge re-request of an already pending selected line survives the clear.
  always_comb begin
    w_pending_next = r_pending | w_req;
    if (w_load) begin
      w_pending_next = (w_cand & ~w_sel_oh) | (w_req & w_sel_oh & r_pending);
    end else begin
      w_pending_next = r_pending | w_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load) w_state_next = S_HOLD;
        else        w_state_next = S_IDLE;
      end
      S_HOLD: begin
        if (w_load)         w_state_next = S_HOLD;
        else if (out_ready) w_state_next = S_IDLE;
        else                w_state_next = S_HOLD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_code_next  = r_code;
    w_valid_next = r_valid;
    w_more_next  = r_more;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_code_next  = w_sel;
          w_valid_next = 1'b1;
          w_more_next  = (w_pending_next != 4'b0000);
        end else begin
          w_valid_next = 1'b0;
          w_more_next  = r_more;
        end
      end
      S_HOLD: begin
        w_cnt_inc = out_ready;
        if (w_load) begin
          w_code_next  = w_sel;
          w_valid_next = 1'b1;
          w_more_next  = (w_pending_next != 4'b0000);
        end else if (out_ready) begin
          w_valid_next = 1'b0;
          w_more_next  = 1'b0;
        end else begin
          w_valid_next = 1'b1;
          w_more_next  = (w_pending_next != 4'b0000);
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_more_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 4'b0000;
      r_code    <= 2'b00;
      r_valid   <= 1'b0;
      r_more    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_code    <= w_code_next;
      r_valid   <= w_valid_next;
      r_more    <= w_more_next;
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign w1         = r_code[1];
  assign w0         = r_code[0];
  assign out_valid  = r_valid;
  assign more       = r_more;
  assign pending    = r_pending;
  assign served_cnt = r_cnt;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Directed bench for req_capture_encoder; a second instance with CNT_W=2 covers the counter wrap.
module tb_req_capture_encoder;

  logic       clk;
  logic       rst_n;
  logic       y3, y2, y1, y0;
  logic       out_ready;
  logic       w1, w0, out_valid, more;
  logic [3:0] pending;
  logic [7:0] served_cnt;
  logic       b_w1, b_w0, b_valid, b_more;
  logic [3:0] b_pending;
  logic [1:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;

  req_capture_encoder #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .w1(w1), .w0(w0), .out_valid(out_valid), .out_ready(out_ready),
    .more(more), .pending(pending), .served_cnt(served_cnt)
  );

  req_capture_encoder #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .w1(b_w1), .w0(b_w0), .out_valid(b_valid), .out_ready(out_ready),
    .more(b_more), .pending(b_pending), .served_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {y3, y2, y1, y0} = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [1:0] sim_codes [3];

  initial begin
`ifdef RR_PRIORITY_EN
    sim_codes[0] = 2'd0; sim_codes[1] = 2'd1; sim_codes[2] = 2'd3;
`else
    sim_codes[0] = 2'd3; sim_codes[1] = 2'd1; sim_codes[2] = 2'd0;
`endif
    rst_n = 1'b0;
    out_ready = 1'b0;
    set_req(4'b0000);
    tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_code", 32'({w1, w0}), 32'd0);
    check_eq("rst_more", 32'(more), 32'd0);
    check_eq("rst_pend", 32'(pending), 32'd0);
    check_eq("rst_cnt", 32'(served_cnt), 32'd0);
    rst_n = 1'b1;

    // single request
    out_ready = 1'b1;
    set_req(4'b0100);
    tick();
    set_req(4'b0000);
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_code", 32'({w1, w0}), 32'd2);
    check_eq("single_more", 32'(more), 32'd0);
    tick();
    check_eq("single_idle", 32'(out_valid), 32'd0);
    check_eq("single_cnt", 32'(served_cnt), 32'd1);

    // simultaneous requests
    do_reset();
    out_ready = 1'b1;
    set_req(4'b1011);
    tick();
    set_req(4'b0000);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("sim_code%0d", i), 32'({w1, w0}), 32'(sim_codes[i]));
      check_eq($sformatf("sim_more%0d", i), 32'(more), (i < 2) ? 32'd1 : 32'd0);
      check_eq($sformatf("sim_valid%0d", i), 32'(out_valid), 32'd1);
      tick();
    end
    check_eq("sim_idle", 32'(out_valid), 32'd0);
    check_eq("sim_cnt", 32'(served_cnt), 32'd3);

    // backpressure with a late higher request
    do_reset();
    out_ready = 1'b0;
    set_req(4'b0010);
    tick();
    set_req(4'b0000);
    check_eq("bp_code0", 32'({w1, w0}), 32'd1);
    check_eq("bp_more0", 32'(more), 32'd0);
    set_req(4'b1000);
    tick();
    set_req(4'b0000);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("bp_hold_code%0d", i), 32'({w1, w0}), 32'd1);
      check_eq($sformatf("bp_hold_more%0d", i), 32'(more), 32'd1);
      check_eq($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      tick();
    end
    check_eq("bp_pend", 32'(pending), 32'h8);
    check_eq("bp_cnt0", 32'(served_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_code1", 32'({w1, w0}), 32'd3);
    check_eq("bp_more1", 32'(more), 32'd0);
    check_eq("bp_cnt1", 32'(served_cnt), 32'd1);
    tick();
    check_eq("bp_idle", 32'(out_valid), 32'd0);
    check_eq("bp_cnt2", 32'(served_cnt), 32'd2);

    // merge: level request held three cycles
    do_reset();
    out_ready = 1'b1;
    set_req(4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) set_req(4'b0000);
      check_eq($sformatf("merge_code%0d", i), 32'({w1, w0}), 32'd0);
      check_eq($sformatf("merge_valid%0d", i), 32'(out_valid), 32'd1);
    end
    tick();
    check_eq("merge_idle", 32'(out_valid), 32'd0);
    check_eq("merge_cnt", 32'(served_cnt), 32'd3);
    check_eq("merge_pend", 32'(pending), 32'd0);

    // re-request of a pending line on its own load edge keeps it pending
    do_reset();
    out_ready = 1'b0;
    set_req(4'b0100);
    tick();
    set_req(4'b0010);
    tick();
    check_eq("rereq_pend0", 32'(pending), 32'h2);
    out_ready = 1'b1;
    tick();
    set_req(4'b0000);
    check_eq("rereq_code0", 32'({w1, w0}), 32'd1);
    check_eq("rereq_pend1", 32'(pending), 32'h2);
    check_eq("rereq_more", 32'(more), 32'd1);
    tick();
    check_eq("rereq_code1", 32'({w1, w0}), 32'd1);
    check_eq("rereq_pend2", 32'(pending), 32'h0);
    check_eq("rereq_more2", 32'(more), 32'd0);

    // asynchronous reset mid-HOLD with pending = 0110
    do_reset();
    out_ready = 1'b0;
    set_req(4'b0001);
    tick();
    set_req(4'b0110);
    tick();
    set_req(4'b0000);
    check_eq("ar_pre_pend", 32'(pending), 32'h6);
    check_eq("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(out_valid), 32'd0);
    check_eq("ar_code", 32'({w1, w0}), 32'd0);
    check_eq("ar_more", 32'(more), 32'd0);
    check_eq("ar_pend", 32'(pending), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ar_stay_idle", 32'(out_valid), 32'd0);

    // counter wrap on the CNT_W=2 instance
    do_reset();
    out_ready = 1'b1;
    set_req(4'b0001);
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) set_req(4'b0000);
      tick();
      check_eq($sformatf("wrap_cnt%0d", i), 32'(b_cnt), 32'(i % 4));
    end
    check_eq("wrap_idle", 32'(b_valid), 32'd0);
    check_eq("wrap_wide_cnt", 32'(served_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
